// File: rtl/adpcm_decoder.sv
// IMA-ADPCM decoder: turns 4-bit ADPCM codes into 16-bit signed PCM samples
// using a five-state shift-add datapath (one code every five clocks). The
// predictor and step index track the encoder state bit-for-bit.
module adpcm_decoder #(
  parameter logic signed [15:0] INIT_PREDICTOR = 16'sd0,
  parameter logic [6:0]         INIT_INDEX     = 7'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync_clr,
  input  logic        code_valid,
  input  logic [3:0]  code,
  output logic        code_ready,
  output logic        pcm_valid,
  output logic [15:0] pcm_out,
  output logic [6:0]  step_index,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BIT2   = 3'd1,
    BIT1   = 3'd2,
    BIT0   = 3'd3,
    UPDATE = 3'd4
  } state_t;

  // Standard 89-entry IMA step ROM; out-of-range indices map to the top step.
  function automatic logic [14:0] step_lookup(input logic [6:0] idx);
    logic [14:0] s;
    case (idx)
      7'd0:  s = 15'd7;     7'd1:  s = 15'd8;     7'd2:  s = 15'd9;     7'd3:  s = 15'd10;
      7'd4:  s = 15'd11;    7'd5:  s = 15'd12;    7'd6:  s = 15'd13;    7'd7:  s = 15'd14;
      7'd8:  s = 15'd16;    7'd9:  s = 15'd17;    7'd10: s = 15'd19;    7'd11: s = 15'd21;
      7'd12: s = 15'd23;    7'd13: s = 15'd25;    7'd14: s = 15'd28;    7'd15: s = 15'd31;
      7'd16: s = 15'd34;    7'd17: s = 15'd37;    7'd18: s = 15'd41;    7'd19: s = 15'd45;
      7'd20: s = 15'd50;    7'd21: s = 15'd55;    7'd22: s = 15'd60;    7'd23: s = 15'd66;
      7'd24: s = 15'd73;    7'd25: s = 15'd80;    7'd26: s = 15'd88;    7'd27: s = 15'd97;
      7'd28: s = 15'd107;   7'd29: s = 15'd118;   7'd30: s = 15'd130;   7'd31: s = 15'd143;
      7'd32: s = 15'd157;   7'd33: s = 15'd173;   7'd34: s = 15'd190;   7'd35: s = 15'd209;
      7'd36: s = 15'd230;   7'd37: s = 15'd253;   7'd38: s = 15'd279;   7'd39: s = 15'd307;
      7'd40: s = 15'd337;   7'd41: s = 15'd371;   7'd42: s = 15'd408;   7'd43: s = 15'd449;
      7'd44: s = 15'd494;   7'd45: s = 15'd544;   7'd46: s = 15'd598;   7'd47: s = 15'd658;
      7'd48: s = 15'd724;   7'd49: s = 15'd796;   7'd50: s = 15'd876;   7'd51: s = 15'd963;
      7'd52: s = 15'd1060;  7'd53: s = 15'd1166;  7'd54: s = 15'd1282;  7'd55: s = 15'd1411;
      7'd56: s = 15'd1552;  7'd57: s = 15'd1707;  7'd58: s = 15'd1878;  7'd59: s = 15'd2066;
      7'd60: s = 15'd2272;  7'd61: s = 15'd2499;  7'd62: s = 15'd2749;  7'd63: s = 15'd3024;
      7'd64: s = 15'd3327;  7'd65: s = 15'd3660;  7'd66: s = 15'd4026;  7'd67: s = 15'd4428;
      7'd68: s = 15'd4871;  7'd69: s = 15'd5358;  7'd70: s = 15'd5894;  7'd71: s = 15'd6484;
      7'd72: s = 15'd7132;  7'd73: s = 15'd7845;  7'd74: s = 15'd8630;  7'd75: s = 15'd9493;
      7'd76: s = 15'd10442; 7'd77: s = 15'd11487; 7'd78: s = 15'd12635; 7'd79: s = 15'd13899;
      7'd80: s = 15'd15289; 7'd81: s = 15'd16818; 7'd82: s = 15'd18500; 7'd83: s = 15'd20350;
      7'd84: s = 15'd22385; 7'd85: s = 15'd24623; 7'd86: s = 15'd27086; 7'd87: s = 15'd29794;
      default: s = 15'd32767;
    endcase
    return s;
  endfunction

  // Index step for a code magnitude: small codes shrink the step, large ones grow it.
  function automatic logic signed [7:0] index_adjust(input logic [2:0] mag);
    logic signed [7:0] a;
    case (mag)
      3'd4:    a = 8'sd2;
      3'd5:    a = 8'sd4;
      3'd6:    a = 8'sd6;
      3'd7:    a = 8'sd8;
      default: a = -8'sd1;
    endcase
    return a;
  endfunction

  // Keep the step index inside the ROM.
  function automatic logic [6:0] clamp_index(input logic signed [7:0] v);
    logic [6:0] r;
    if (v < 8'sd0) begin
      r = 7'd0;
    end else if (v > 8'sd88) begin
      r = 7'd88;
    end else begin
      r = v[6:0];
    end
    return r;
  endfunction

  // Saturate the widened predictor sum back to 16-bit signed.
  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    logic signed [15:0] r;
    if (v > 18'sd32767) begin
      r = 16'sh7FFF;
    end else if (v < -18'sd32768) begin
      r = -16'sd32768;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  state_t             state_r, state_s;
  logic [3:0]         code_r, code_s;
  logic [14:0]        step_r, step_s;
  logic [17:0]        diff_r, diff_s;
  logic signed [15:0] pred_r, pred_s;
  logic [6:0]         index_r, index_s;
  logic               pcm_valid_r, pcm_valid_s;
  logic               overrun_r, overrun_s;
  logic [14:0]        step_l_s;
  logic signed [17:0] sum_s;

  // Next-state and datapath: sync_clr overrides everything, including a same-cycle code.
  always_comb begin
    state_s     = state_r;
    code_s      = code_r;
    step_s      = step_r;
    diff_s      = diff_r;
    pred_s      = pred_r;
    index_s     = index_r;
    pcm_valid_s = 1'b0;
    overrun_s   = overrun_r;
    step_l_s    = step_lookup(index_r);
    sum_s       = 18'sd0;
    if (sync_clr) begin
      state_s   = IDLE;
      code_s    = 4'd0;
      step_s    = 15'd0;
      diff_s    = 18'd0;
      pred_s    = INIT_PREDICTOR;
      index_s   = INIT_INDEX;
      overrun_s = 1'b0;
    end else begin
      if (code_valid && (state_r != IDLE)) begin
        overrun_s = 1'b1;
      end else begin
        overrun_s = overrun_r;
      end
      case (state_r)
        IDLE: begin
          if (code_valid) begin
            code_s  = code;
            step_s  = step_l_s;
            diff_s  = {6'b000000, step_l_s[14:3]};
            state_s = BIT2;
          end else begin
            state_s = IDLE;
          end
        end
        BIT2: begin
          if (code_r[2]) begin
            diff_s = diff_r + {3'b000, step_r};
          end else begin
            diff_s = diff_r;
          end
          state_s = BIT1;
        end
        BIT1: begin
          if (code_r[1]) begin
            diff_s = diff_r + {4'b0000, step_r[14:1]};
          end else begin
            diff_s = diff_r;
          end
          state_s = BIT0;
        end
        BIT0: begin
          if (code_r[0]) begin
            diff_s = diff_r + {5'b00000, step_r[14:2]};
          end else begin
            diff_s = diff_r;
          end
          state_s = UPDATE;
        end
        UPDATE: begin
          if (code_r[3]) begin
            sum_s = $signed({{2{pred_r[15]}}, pred_r}) - $signed(diff_r);
          end else begin
            sum_s = $signed({{2{pred_r[15]}}, pred_r}) + $signed(diff_r);
          end
          pred_s      = sat16(sum_s);
          index_s     = clamp_index($signed({1'b0, index_r}) + index_adjust(code_r[2:0]));
          pcm_valid_s = 1'b1;
          state_s     = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset to the initial predictor/index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      code_r      <= 4'd0;
      step_r      <= 15'd0;
      diff_r      <= 18'd0;
      pred_r      <= INIT_PREDICTOR;
      index_r     <= INIT_INDEX;
      pcm_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      code_r      <= code_s;
      step_r      <= step_s;
      diff_r      <= diff_s;
      pred_r      <= pred_s;
      index_r     <= index_s;
      pcm_valid_r <= pcm_valid_s;
      overrun_r   <= overrun_s;
    end
  end

  assign code_ready = (state_r == IDLE);
  assign pcm_valid  = pcm_valid_r;
  assign pcm_out    = pred_r;
  assign step_index = index_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_adpcm_decoder.sv
// Self-checking bench for adpcm_decoder: three instances with different
// initial predictor/index share one code stream and are compared against
// an arithmetic IMA reference model.
module tb_adpcm_decoder;

  logic       clk;
  logic       rst_n;
  logic       sync_clr;
  logic       code_valid;
  logic [3:0] code;

  logic        cr [3];
  logic        pv [3];
  logic [15:0] pcm_o [3];
  logic [6:0]  si [3];
  logic        ov [3];

  int checks;
  int failures;

  int step_tab [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
    3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442,
    11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794,
    32767};

  int init_p [3] = '{0, 32760, -32760};
  int init_i [3] = '{0, 88, 88};
  int mp [3];
  int mi [3];

  adpcm_decoder u_dut0 (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .code_valid(code_valid), .code(code),
    .code_ready(cr[0]), .pcm_valid(pv[0]), .pcm_out(pcm_o[0]), .step_index(si[0]), .overrun(ov[0]));

  adpcm_decoder #(.INIT_PREDICTOR(16'sd32760), .INIT_INDEX(7'd88)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .code_valid(code_valid), .code(code),
    .code_ready(cr[1]), .pcm_valid(pv[1]), .pcm_out(pcm_o[1]), .step_index(si[1]), .overrun(ov[1]));

  adpcm_decoder #(.INIT_PREDICTOR(-16'sd32760), .INIT_INDEX(7'd88)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .code_valid(code_valid), .code(code),
    .code_ready(cr[2]), .pcm_valid(pv[2]), .pcm_out(pcm_o[2]), .step_index(si[2]), .overrun(ov[2]));

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mp[i] = init_p[i];
      mi[i] = init_i[i];
    end
  endtask

  // Reference decode: diff from the step table, saturating predictor, clamped index.
  task automatic model_apply(input int c);
    int st, d, p, m, ni;
    for (int i = 0; i < 3; i++) begin
      st = step_tab[mi[i]];
      m  = c % 8;
      d  = st / 8;
      if ((c / 4) % 2 == 1) d = d + st;
      if ((c / 2) % 2 == 1) d = d + st / 2;
      if (c % 2 == 1)       d = d + st / 4;
      p = (c >= 8) ? mp[i] - d : mp[i] + d;
      if (p > 32767)  p = 32767;
      if (p < -32768) p = -32768;
      ni = (m < 4) ? mi[i] - 1 : mi[i] + 2 * (m - 3);
      if (ni < 0)  ni = 0;
      if (ni > 88) ni = 88;
      mp[i] = p;
      mi[i] = ni;
    end
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_pcm%0d", tag, i), int'($signed(pcm_o[i])), mp[i]);
      check($sformatf("%s_idx%0d", tag, i), int'(si[i]), mi[i]);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_valid", int'(pv[0]), 0);
    check("rst_overrun", int'(ov[0]), 0);
    check_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", int'(cr[0]), 1);
  endtask

  // One code with latency/ready-window checks; then the model advances.
  task automatic decode(input int c, input string tag);
    int lat, rl;
    bit got;
    @(negedge clk);
    code_valid = 1'b1;
    code = c[3:0];
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    lat = 0;
    rl = (cr[0] == 1'b0) ? 1 : 0;
    got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(posedge clk);
      #1;
      if (pv[0]) begin
        got = 1'b1;
        lat = k;
      end else if (!cr[0]) begin
        rl++;
      end
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_ready_low"}, rl, 4);
    model_apply(c);
    check_state(tag);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, int'(pv[0]), 0);
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (pv[0] || pv[1] || pv[2]) cnt++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, c;
    checks = 0;
    failures = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    sync_clr = 1'b0;
    code_valid = 1'b0;
    code = 4'd0;
    repeat (2) @(posedge clk);

    // Cases 1, 2 and saturation/clamp on the other instances.
    apply_reset();
    decode(7, "c7");
    check("c7_pcm_const", int'($signed(pcm_o[0])), 11);
    check("c7_idx_const", int'(si[0]), 8);
    check("sat_hi_const", int'($signed(pcm_o[1])), 32767);
    check("clamp88_const", int'(si[1]), 88);
    decode(15, "cF");
    check("cF_pcm_const", int'(pcm_o[0]), 16'hFFED);
    check("cF_idx_const", int'(si[0]), 16);

    // Case 3: index clamps at zero; case 4 negative saturation.
    apply_reset();
    decode(0, "c0");
    decode(8, "c8");
    check("c8_idx_const", int'(si[0]), 0);
    apply_reset();
    decode(15, "negsat");
    check("sat_lo_const", int'($signed(pcm_o[2])), -32768);

    // Case 5: code pulsed during BIT1 is dropped and flags overrun.
    apply_reset();
    @(negedge clk); code_valid = 1'b1; code = 4'd5;
    @(posedge clk); #1; code_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); code_valid = 1'b1; code = 4'd3;
    @(posedge clk); #1; code_valid = 1'b0;
    check("ovr_set", int'(ov[0]), 1);
    @(posedge clk);
    @(posedge clk); #1;
    check("ovr_first_valid", int'(pv[0]), 1);
    model_apply(5);
    check_state("ovr_first");
    @(negedge clk); sync_clr = 1'b1;
    @(posedge clk); #1; sync_clr = 1'b0;
    model_reset();
    check("clr_overrun", int'(ov[0]), 0);
    check_state("clr");

    // Clear with a same-cycle code: code dropped, no overrun.
    @(negedge clk); sync_clr = 1'b1; code_valid = 1'b1; code = 4'd7;
    @(posedge clk); #1; sync_clr = 1'b0; code_valid = 1'b0;
    check("clr_code_ready", int'(cr[0]), 1);
    check("clr_code_ovr", int'(ov[0]), 0);
    count_valid(6, cnt);
    check("clr_code_novalid", cnt, 0);
    check_state("clr_code");

    // Clear landing in UPDATE: no sample, no predictor change.
    @(negedge clk); code_valid = 1'b1; code = 4'd7;
    @(posedge clk); #1; code_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); sync_clr = 1'b1;
    @(posedge clk); #1; sync_clr = 1'b0;
    cnt = pv[0] ? 1 : 0;
    check("clr_upd_now", cnt, 0);
    count_valid(6, cnt);
    check("clr_upd_novalid", cnt, 0);
    check_state("clr_upd");

    // Case 6: async reset during BIT0.
    @(negedge clk); code_valid = 1'b1; code = 4'd7;
    @(posedge clk); #1; code_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("arst_ready", int'(cr[0]), 1);
    @(negedge clk); rst_n = 1'b1;
    count_valid(8, cnt);
    check("arst_novalid", cnt, 0);
    check_state("arst");

    // Back-to-back random codes, one every five clocks.
    for (int n = 0; n < 1000; n++) begin
      c = $urandom_range(0, 15);
      @(negedge clk); code_valid = 1'b1; code = c[3:0];
      @(posedge clk); #1; code_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      check("rnd_valid", int'(pv[0]), 1);
      model_apply(c);
      for (int i = 0; i < 3; i++) begin
        check("rnd_pcm", int'($signed(pcm_o[i])), mp[i]);
        check("rnd_idx", int'(si[i]), mi[i]);
      end
    end
    for (int i = 0; i < 3; i++) check("rnd_overrun", int'(ov[i]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
